fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the instruction queue entry count (fixed at 2 for this release).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_i  input  1  high enables issue of new fetch requests.
REQ-006 SHALL have port stall_i  input  1  hazard stall from the hazard unit; high blocks dequeue.
REQ-007 SHALL have port flush_i  input  1  branch-taken redirect strobe.
REQ-008 SHALL have port redirect_addr_i  input  32  branch target, sampled when flush_i is high.
REQ-009 SHALL have port imem_req_o  output  1  instruction-memory request.
REQ-010 SHALL have port imem_addr_o  output  32  request address.
REQ-011 SHALL have port imem_ack_i  input  1  memory returns data this cycle.
REQ-012 SHALL have port imem_data_i  input  32  instruction word, valid with imem_ack_i.
REQ-013 SHALL have port inst_o  output  32  queue-head instruction to the IF/ID register.
REQ-014 SHALL have port pc_plus4_o  output  32  queue-head address plus 4.
REQ-015 SHALL have port inst_valid_o  output  1  queue non-empty.

Function
REQ-016 SHALL implement FSM states IDLE (no request), REQ (request outstanding, data kept), DISCARD (request outstanding, data dropped).
REQ-017 SHALL go IDLE->REQ when start_i=1 and (queue count) < DEPTH; request address is fetch_pc.
REQ-018 SHALL hold imem_req_o=1 and imem_addr_o stable from entry to REQ/DISCARD until the cycle imem_ack_i=1 inclusive; ack with imem_req_o=0 is ignored.
REQ-019 SHALL allow at most one outstanding request; a queue slot is reserved at issue so a push never overflows.
REQ-020 SHALL, on ack in REQ, push {imem_data_i, fetch_pc+4}, advance fetch_pc by 4, and go to REQ again if start_i=1 and a slot remains after the push, otherwise IDLE.
REQ-021 SHALL dequeue the head in any cycle where inst_valid_o=1, stall_i=0, flush_i=0.
REQ-022 SHALL keep count unchanged on simultaneous push and dequeue; the pushed entry lands behind the remaining one.
REQ-023 SHALL, on flush_i=1, empty the queue, load fetch_pc with {redirect_addr_i[31:2],2'b00}, and go REQ->DISCARD (or IDLE stays IDLE); flush outranks push, dequeue and stall.
REQ-024 SHALL, on ack in DISCARD, drop the data and issue at the redirected fetch_pc the next cycle if start_i=1, else IDLE.
REQ-025 SHALL treat flush while in DISCARD as updating fetch_pc only.
REQ-026 SHALL drive inst_o=32'h0 (NOP) and pc_plus4_o=0 when the queue is empty.
REQ-027 SHALL compute all address arithmetic modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000).
REQ-028 SHALL, with start_i=0, issue no new requests but complete an outstanding one.
REQ-029 SHALL give minimum latency of 1 cycle from ack to inst_valid_o=1.

Reset
REQ-030 SHALL, while rst_i=0, force state IDLE, fetch_pc=RESET_PC, queue empty, imem_req_o=0, imem_addr_o=RESET_PC, inst_o=0, pc_plus4_o=0, inst_valid_o=0, regardless of clk_i.
REQ-031 SHALL abandon an outstanding request on reset; the memory is reset by the same rst_i.

Structure
REQ-032 SHALL take RESET_PC default, NOP encoding 32'h0 and FSM state encoding from the shared package cpu_pkg.
REQ-033 SHALL instantiate one sub-module fetch_fifo (2-entry, 64-bit entries, push/pop/flush, count output).

Verification
REQ-034 SHALL cover: reset, start_i=1, ack 1 cycle after each req -> addresses 0,4,8; inst_o words in order; pc_plus4_o 4,8,12.
REQ-035 SHALL cover: stall_i=1 for 5 cycles -> queue fills to 2, imem_req_o stays 0, head holds; release -> pops resume, no loss.
REQ-036 SHALL cover: flush_i with redirect 0x100 while request to 0x8 pending -> 0x8 data dropped, next request 0x100, inst_valid_o=0 until its ack.
REQ-037 SHALL cover: flush_i with simultaneous ack and dequeue -> queue empty next cycle, fetch_pc=redirect.
REQ-038 SHALL cover: RESET_PC=0xFFFF_FFFC -> second request address 0x0, pc_plus4_o of first entry 0x0.
REQ-039 SHALL cover: rst_i low mid-request (imem_req_o=1) -> outputs at reset values asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch FSM encoding.
// The reset fetch address, the NOP word and the state values all live here so every stage agrees on them.
package cpu_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam int          ENTRY_W          = 64;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus seen from the fetch side (master) and the memory side (slave).
// req rises with a stable addr and stays up until the cycle ack=1 (inclusive); data is valid only with ack.
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] data;

   modport master (output req, output addr, input ack, input data);
   modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/fetch_unit_fifo.sv
// Two-entry instruction queue: entry = {instruction, address+4}; slot0 is always the head.
// Callers never pop when empty and never push when full, so neither case is guarded here.
module fetch_fifo
   import cpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [ENTRY_W-1:0] din,
   output logic [ENTRY_W-1:0] head,
   output logic [1:0]         count
);
   logic [ENTRY_W-1:0] slot0, slot1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) slot0 <= din;
               else               slot1 <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               count <= count - 2'd1;
            end
            2'b11: begin
               // The new entry always lands behind whatever survives the pop.
               if (count == 2'd1) begin
                  slot0 <= din;
               end else begin
                  slot0 <= slot1;
                  slot1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = slot0;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request feeding a two-entry queue, with branch redirect.
// A queue slot is reserved when a request issues, so the push on ack can never overflow.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         stall_i,
   input  logic         flush_i,
   input  logic [31:0]  redirect_addr_i,
   output logic         imem_req_o,
   output logic [31:0]  imem_addr_o,
   input  logic         imem_ack_i,
   input  logic [31:0]  imem_data_i,
   output logic [31:0]  inst_o,
   output logic [31:0]  pc_plus4_o,
   output logic         inst_valid_o,
   output fetch_state_t dbg_state
);
   localparam logic [2:0] DEPTH_W = 3'(DEPTH);

   fetch_state_t       state, state_next;
   logic [31:0]        fetch_pc, fetch_pc_next;
   logic [31:0]        req_addr, req_addr_next;
   logic [31:0]        redirect_pc;
   logic               push, pop;
   logic [1:0]         count;
   logic [2:0]         count_after_push;
   logic [ENTRY_W-1:0] head;

   assign redirect_pc      = align_word(redirect_addr_i);
   assign inst_valid_o     = (count != 2'd0);
   assign pop              = inst_valid_o && !stall_i && !flush_i;
   assign count_after_push = {1'b0, count} + 3'd1 - {2'b00, pop};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         req_addr <= req_addr_next;
      end
   end

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      req_addr_next = req_addr;
      push          = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (flush_i) begin
               fetch_pc_next = redirect_pc;
            end else if (start_i && ({1'b0, count} < DEPTH_W)) begin
               state_next    = ST_REQ;
               req_addr_next = fetch_pc;
            end
         end
         ST_REQ: begin
            if (flush_i) begin
               fetch_pc_next = redirect_pc;
            end else if (imem_ack_i) begin
               push          = 1'b1;
               fetch_pc_next = fetch_pc + 32'd4;
            end
            // Flush together with ack completes the request, so there is nothing left to discard.
            if (imem_ack_i) begin
               if (start_i && (flush_i || (count_after_push < DEPTH_W))) begin
                  state_next    = ST_REQ;
                  req_addr_next = fetch_pc_next;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (flush_i) begin
               state_next = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (flush_i) fetch_pc_next = redirect_pc;
            if (imem_ack_i) begin
               if (start_i) begin
                  state_next    = ST_REQ;
                  req_addr_next = fetch_pc_next;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   fetch_fifo u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (push),
      .pop   (pop),
      .flush (flush_i),
      .din   ({imem_data_i, fetch_pc + 32'd4}),
      .head  (head),
      .count (count)
   );

   assign imem_req_o  = (state != ST_IDLE);
   assign imem_addr_o = req_addr;
   assign inst_o      = inst_valid_o ? head[63:32] : NOP;
   assign pc_plus4_o  = inst_valid_o ? head[31:0]  : 32'h0;
   assign dbg_state   = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a per-cycle vector table, then a memory model with a scoreboard for
// stall, flush, wrap-around, asynchronous reset and a randomized run.
module tb_fetch_unit;
   import cpu_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [31:0]  redirect = 32'h0;
   logic [31:0]  inst, pc4;
   logic         valid;
   fetch_state_t state;
   logic         start2 = 1'b0, stall2 = 1'b0;
   logic [31:0]  inst2, pc4_2;
   logic         valid2;
   fetch_state_t state2;

   fetch_unit_if mif();
   fetch_unit_if mif2();

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk_i(clk), .rst_i(rst_n), .start_i(start), .stall_i(stall), .flush_i(flush),
      .redirect_addr_i(redirect), .imem_req_o(mif.req), .imem_addr_o(mif.addr),
      .imem_ack_i(mif.ack), .imem_data_i(mif.data), .inst_o(inst), .pc_plus4_o(pc4),
      .inst_valid_o(valid), .dbg_state(state)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i(clk), .rst_i(rst_n), .start_i(start2), .stall_i(stall2), .flush_i(1'b0),
      .redirect_addr_i(32'h0), .imem_req_o(mif2.req), .imem_addr_o(mif2.addr),
      .imem_ack_i(mif2.ack), .imem_data_i(mif2.data), .inst_o(inst2), .pc_plus4_o(pc4_2),
      .inst_valid_o(valid2), .dbg_state(state2)
   );

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];
   logic [31:0] exp_pc;
   logic        live;
   int          wait_cnt;
   int          mem_lat;
   logic        rand_lat;

   typedef struct {
      logic        start, stall, flush;
      logic [31:0] redir;
      logic        ack;
      logic [31:0] data;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc4;
   } vec_t;

   vec_t vec[21];

   function automatic vec_t mk(input logic st, input logic sl, input logic fl, input logic [31:0] rd,
                               input logic ak, input logic [31:0] dt, input logic rq,
                               input logic [31:0] ad, input logic vl, input logic [31:0] in,
                               input logic [31:0] p4);
      vec_t v;
      v.start = st; v.stall = sl; v.flush = fl; v.redir = rd; v.ack = ak; v.data = dt;
      v.req = rq; v.addr = ad; v.valid = vl; v.inst = in; v.pc4 = p4;
      return v;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a ^ 32'hC0DE_0000) + 32'h0000_0011;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 32'h0;
      mif.ack = 1'b0; mif.data = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      exp_pc = 32'h0;
      live = 1'b1;
      wait_cnt = 0;
   endtask

   // One cycle driven by the memory model; expected entries come from the bench's own fetch_pc.
   task automatic tick(input logic st, input logic sl, input logic fl, input logic [31:0] rd);
      logic [63:0] e;
      logic        acked, pending;
      start = st; stall = sl; flush = fl; redirect = rd;
      if (mif.req && wait_cnt >= mem_lat) begin
         mif.ack = 1'b1;
         mif.data = word_of(mif.addr);
      end else begin
         mif.ack = !mif.req && rand_lat && ($urandom_range(0, 7) == 0);
         mif.data = $urandom;
      end
      #1;
      chk("sb_valid", 32'(valid), 32'(exp_q.size() != 0));
      if (exp_q.size() == 0) begin
         chk("sb_nop_inst", inst, 32'h0);
         chk("sb_nop_pc4", pc4, 32'h0);
      end
      acked = mif.req && mif.ack;
      pending = mif.req;
      if (fl) begin
         exp_q.delete();
         if (acked) live = 1'b1;
         else if (pending) live = 1'b0;
         exp_pc = {rd[31:2], 2'b00};
      end else begin
         if (valid && !sl && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_inst", inst, e[63:32]);
            chk("sb_pc4", pc4, e[31:0]);
         end
         if (acked) begin
            if (live) begin
               chk("sb_addr", mif.addr, exp_pc);
               exp_q.push_back({word_of(exp_pc), exp_pc + 32'd4});
               exp_pc = exp_pc + 32'd4;
            end else begin
               live = 1'b1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (acked) begin
         wait_cnt = 0;
         if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else if (pending) begin
         wait_cnt++;
      end else begin
         wait_cnt = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      mif.ack = 1'b0; mif.data = 32'h0;
      mif2.ack = 1'b0; mif2.data = 32'h0;
      mem_lat = 1; rand_lat = 1'b0; live = 1'b1; wait_cnt = 0; exp_pc = 32'h0;

      // Rows 0-7: ack one cycle after each request. Rows 8-20: redirect while the 0x8 request is pending.
      vec[0]  = mk(1,0,0,32'h0,   0,32'h0,         0,32'h0,   0,32'h0,         32'h0);
      vec[1]  = mk(1,0,0,32'h0,   0,32'h0,         1,32'h0,   0,32'h0,         32'h0);
      vec[2]  = mk(1,0,0,32'h0,   1,32'h1111_0000, 1,32'h0,   0,32'h0,         32'h0);
      vec[3]  = mk(1,0,0,32'h0,   0,32'h0,         1,32'h4,   1,32'h1111_0000, 32'h4);
      vec[4]  = mk(1,0,0,32'h0,   1,32'h2222_0004, 1,32'h4,   0,32'h0,         32'h0);
      vec[5]  = mk(1,0,0,32'h0,   0,32'h0,         1,32'h8,   1,32'h2222_0004, 32'h8);
      vec[6]  = mk(1,0,0,32'h0,   1,32'h3333_0008, 1,32'h8,   0,32'h0,         32'h0);
      vec[7]  = mk(1,0,0,32'h0,   0,32'h0,         1,32'hC,   1,32'h3333_0008, 32'hC);
      vec[8]  = mk(1,0,0,32'h0,   0,32'h0,         0,32'h0,   0,32'h0,         32'h0);
      vec[9]  = mk(1,0,0,32'h0,   1,32'hAAAA_0000, 1,32'h0,   0,32'h0,         32'h0);
      vec[10] = mk(1,0,0,32'h0,   1,32'hBBBB_0004, 1,32'h4,   1,32'hAAAA_0000, 32'h4);
      vec[11] = mk(1,0,1,32'h100, 0,32'h0,         1,32'h8,   1,32'hBBBB_0004, 32'h8);
      vec[12] = mk(1,0,0,32'h0,   0,32'h0,         1,32'h8,   0,32'h0,         32'h0);
      vec[13] = mk(1,0,0,32'h0,   1,32'hDEAD_BEEF, 1,32'h8,   0,32'h0,         32'h0);
      vec[14] = mk(1,0,0,32'h0,   0,32'h0,         1,32'h100, 0,32'h0,         32'h0);
      vec[15] = mk(1,0,0,32'h0,   1,32'hCCCC_0100, 1,32'h100, 0,32'h0,         32'h0);
      vec[16] = mk(0,0,0,32'h0,   0,32'h0,         1,32'h104, 1,32'hCCCC_0100, 32'h104);
      vec[17] = mk(0,0,0,32'h0,   1,32'hDDDD_0104, 1,32'h104, 0,32'h0,         32'h0);
      vec[18] = mk(0,0,0,32'h0,   0,32'h0,         0,32'h104, 1,32'hDDDD_0104, 32'h108);
      vec[19] = mk(0,0,0,32'h0,   1,32'h5555_5555, 0,32'h104, 0,32'h0,         32'h0);
      vec[20] = mk(0,0,0,32'h0,   0,32'h0,         0,32'h104, 0,32'h0,         32'h0);

      @(negedge clk);
      #1;
      chk("rst_req", 32'(mif.req), 32'(1'b0));
      chk("rst_addr", mif.addr, 32'h0);
      chk("rst_valid", 32'(valid), 32'(1'b0));
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      chk("rst_wrap_addr", mif2.addr, 32'hFFFF_FFFC);

      for (int i = 0; i < 21; i++) begin
         if (i == 0 || i == 8) do_reset();
         start = vec[i].start; stall = vec[i].stall; flush = vec[i].flush;
         redirect = vec[i].redir; mif.ack = vec[i].ack; mif.data = vec[i].data;
         #1;
         chk($sformatf("row%0d_req", i), 32'(mif.req), 32'(vec[i].req));
         chk($sformatf("row%0d_addr", i), mif.addr, vec[i].addr);
         chk($sformatf("row%0d_valid", i), 32'(valid), 32'(vec[i].valid));
         chk($sformatf("row%0d_inst", i), inst, vec[i].inst);
         chk($sformatf("row%0d_pc4", i), pc4, vec[i].pc4);
         @(posedge clk);
         @(negedge clk);
      end

      // Stall: the queue fills to two, requests stop, the head holds; release drains with no loss.
      do_reset();
      mem_lat = 1; rand_lat = 1'b0;
      repeat (7) tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_req_off", 32'(mif.req), 32'(1'b0));
      chk("stall_head_inst", inst, word_of(32'h0));
      chk("stall_head_pc4", pc4, 32'h4);
      repeat (12) tick(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (12) tick(1'b0, 1'b0, 1'b0, 32'h0);
      chk("stall_drained", 32'(exp_q.size()), 32'h0);

      // Flush in the same cycle as an ack and a dequeue.
      do_reset();
      mem_lat = 0;
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 32'h0000_0203);
      chk("flush_ack_empty", 32'(valid), 32'(1'b0));
      chk("flush_ack_req", 32'(mif.req), 32'(1'b1));
      chk("flush_ack_addr", mif.addr, 32'h0000_0200);
      repeat (6) tick(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (8) tick(1'b0, 1'b0, 1'b0, 32'h0);

      // Asynchronous reset while a request is outstanding.
      do_reset();
      mem_lat = 6;
      repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(mif.req), 32'(1'b0));
      chk("arst_addr", mif.addr, 32'h0);
      chk("arst_valid", 32'(valid), 32'(1'b0));
      chk("arst_inst", inst, 32'h0);
      chk("arst_pc4", pc4, 32'h0);
      chk("arst_state", 32'(state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); exp_pc = 32'h0; live = 1'b1; wait_cnt = 0; mem_lat = 1;
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      chk("arst_restart_req", 32'(mif.req), 32'(1'b1));
      chk("arst_restart_addr", mif.addr, 32'h0);
      repeat (8) tick(1'b1, 1'b0, 1'b0, 32'h0);

      // Address wrap: first request at 0xFFFF_FFFC, the next at 0x0.
      do_reset();
      start2 = 1'b1; stall2 = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("wrap_req1", 32'(mif2.req), 32'(1'b1));
      chk("wrap_addr1", mif2.addr, 32'hFFFF_FFFC);
      mif2.ack = 1'b1; mif2.data = 32'hABCD_0001;
      @(posedge clk); @(negedge clk);
      mif2.ack = 1'b0; start2 = 1'b0;
      chk("wrap_addr2", mif2.addr, 32'h0);
      chk("wrap_valid", 32'(valid2), 32'(1'b1));
      chk("wrap_inst", inst2, 32'hABCD_0001);
      chk("wrap_pc4", pc4_2, 32'h0);

      // Randomized run against the scoreboard.
      do_reset();
      rand_lat = 1'b1; mem_lat = $urandom_range(0, 3);
      for (int n = 0; n < 400; n++) begin
         tick($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0, $urandom);
      end
      repeat (15) tick(1'b0, 1'b0, 1'b0, 32'h0);
      chk("rand_drained", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
